// File: rtl/fireball_ctrl.sv
// Fireball sprite sequencer: launch handshake, per-frame motion, edge exit or hit,
// explosion timing and relaunch cooldown for a single on-screen sprite.
module fireball_ctrl #(
    parameter int FB_WIDTH        = 64,
    parameter int FB_HEIGHT       = 64,
    parameter int SCREEN_W        = 800,
    parameter int SCREEN_H        = 600,
    parameter int BOOM_FRAMES     = 8,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       launch_req,
    input  logic [9:0] launch_h,
    input  logic [9:0] launch_v,
    input  logic [9:0] launch_h_speed,
    input  logic [9:0] launch_v_speed,
    input  logic       launch_h_neg,
    input  logic       launch_v_neg,
    input  logic       hit,
    output logic       launch_ack,
    output logic [9:0] fireball_h_coord,
    output logic [9:0] fireball_v_coord,
    output logic       fireball_active,
    output logic       fireball_exploding,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FLY  = 2'd1,
        ST_BOOM = 2'd2,
        ST_COOL = 2'd3
    } state_t;

    localparam logic        HAS_COOL  = (COOLDOWN_FRAMES != 0);
    localparam logic [15:0] BOOM_LAST = 16'(BOOM_FRAMES - 1);
    localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_FRAMES - 1);
    localparam logic [10:0] H_LIMIT   = 11'(SCREEN_W - 1);
    localparam logic [10:0] V_LIMIT   = 11'(SCREEN_H - 1);
    localparam logic [10:0] H_SIZE    = 11'(FB_WIDTH);
    localparam logic [10:0] V_SIZE    = 11'(FB_HEIGHT + 1);

    state_t      state_r, state_s;
    logic [9:0]  h_r, v_r, h_speed_r, v_speed_r;
    logic        h_neg_r, v_neg_r;
    logic [15:0] cnt_r;
    logic        ack_r, active_r, exploding_r, busy_r;

    logic        load_s, step_s, cnt_clr_s, cnt_inc_s, ack_s;
    logic [10:0] h_far_s, v_far_s;
    logic        exit_h_s, exit_v_s;
    logic [9:0]  h_next_s, v_next_s;
    state_t      after_boom_s;

    // Exit test on current coordinates; a zero-speed axis can never exit.
    always_comb begin
        h_far_s  = {1'b0, h_r} + H_SIZE + {1'b0, h_speed_r};
        v_far_s  = {1'b0, v_r} + V_SIZE + {1'b0, v_speed_r};
        exit_h_s = 1'b0;
        exit_v_s = 1'b0;
        if (h_speed_r != 10'd0) begin
            exit_h_s = h_neg_r ? (h_r < h_speed_r) : (h_far_s > H_LIMIT);
        end else begin
            exit_h_s = 1'b0;
        end
        if (v_speed_r != 10'd0) begin
            exit_v_s = v_neg_r ? (v_r < v_speed_r) : (v_far_s > V_LIMIT);
        end else begin
            exit_v_s = 1'b0;
        end
        h_next_s     = h_neg_r ? (h_r - h_speed_r) : (h_r + h_speed_r);
        v_next_s     = v_neg_r ? (v_r - v_speed_r) : (v_r + v_speed_r);
        after_boom_s = HAS_COOL ? ST_COOL : ST_IDLE;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_s   = state_r;
        load_s    = 1'b0;
        step_s    = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        ack_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (launch_req) begin
                    state_s   = ST_FLY;
                    load_s    = 1'b1;
                    ack_s     = 1'b1;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLY: begin
                if (hit) begin
                    state_s   = ST_BOOM;
                    cnt_clr_s = 1'b1;
                end else if (frame_tick) begin
                    if (exit_h_s || exit_v_s) begin
                        state_s   = after_boom_s;
                        cnt_clr_s = 1'b1;
                    end else begin
                        step_s = 1'b1;
                    end
                end else begin
                    state_s = ST_FLY;
                end
            end
            ST_BOOM: begin
                if (frame_tick) begin
                    if (cnt_r == BOOM_LAST) begin
                        state_s   = after_boom_s;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    state_s = ST_BOOM;
                end
            end
            ST_COOL: begin
                if (frame_tick) begin
                    if (cnt_r == COOL_LAST) begin
                        state_s   = ST_IDLE;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    state_s = ST_COOL;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State, counter and status flags; flags follow the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            ack_r       <= 1'b0;
            active_r    <= 1'b0;
            exploding_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ack_r       <= ack_s;
            active_r    <= (state_s == ST_FLY);
            exploding_r <= (state_s == ST_BOOM);
            busy_r      <= (state_s != ST_IDLE);
            if (cnt_clr_s) begin
                cnt_r <= 16'd0;
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Position, speed and direction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_r       <= 10'd0;
            v_r       <= 10'd0;
            h_speed_r <= 10'd0;
            v_speed_r <= 10'd0;
            h_neg_r   <= 1'b0;
            v_neg_r   <= 1'b0;
        end else if (load_s) begin
            h_r       <= launch_h;
            v_r       <= launch_v;
            h_speed_r <= launch_h_speed;
            v_speed_r <= launch_v_speed;
            h_neg_r   <= launch_h_neg;
            v_neg_r   <= launch_v_neg;
        end else if (step_s) begin
            h_r <= h_next_s;
            v_r <= v_next_s;
        end else begin
            h_r <= h_r;
            v_r <= v_r;
        end
    end

    assign launch_ack         = ack_r;
    assign fireball_h_coord   = h_r;
    assign fireball_v_coord   = v_r;
    assign fireball_active    = active_r;
    assign fireball_exploding = exploding_r;
    assign busy               = busy_r;

endmodule

// File: tb/tb_fireball_ctrl.sv
// Directed bench for fireball_ctrl: instance "a" uses the default cooldown,
// instance "b" has no cooldown; both share the same stimulus.
module tb_fireball_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       launch_req = 1'b0;
    logic [9:0] launch_h = 10'd0, launch_v = 10'd0;
    logic [9:0] launch_h_speed = 10'd0, launch_v_speed = 10'd0;
    logic       launch_h_neg = 1'b0, launch_v_neg = 1'b0;
    logic       hit = 1'b0;

    logic       ack_a, act_a, exp_a, busy_a;
    logic [9:0] h_a, v_a;
    logic       ack_b, act_b, exp_b, busy_b;
    logic [9:0] h_b, v_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fireball_ctrl dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch_req(launch_req),
        .launch_h(launch_h), .launch_v(launch_v),
        .launch_h_speed(launch_h_speed), .launch_v_speed(launch_v_speed),
        .launch_h_neg(launch_h_neg), .launch_v_neg(launch_v_neg), .hit(hit),
        .launch_ack(ack_a), .fireball_h_coord(h_a), .fireball_v_coord(v_a),
        .fireball_active(act_a), .fireball_exploding(exp_a), .busy(busy_a)
    );

    fireball_ctrl #(.COOLDOWN_FRAMES(0)) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .launch_req(launch_req),
        .launch_h(launch_h), .launch_v(launch_v),
        .launch_h_speed(launch_h_speed), .launch_v_speed(launch_v_speed),
        .launch_h_neg(launch_h_neg), .launch_v_neg(launch_v_neg), .hit(hit),
        .launch_ack(ack_b), .fireball_h_coord(h_b), .fireball_v_coord(v_b),
        .fireball_active(act_b), .fireball_exploding(exp_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic launch(input logic [9:0] h, input logic [9:0] v, input logic [9:0] hs,
                          input logic [9:0] vs, input logic hn, input logic vn);
        launch_h = h; launch_v = v; launch_h_speed = hs; launch_v_speed = vs;
        launch_h_neg = hn; launch_v_neg = vn;
        launch_req = 1'b1;
        step();
        launch_req = 1'b0;
    endtask

    initial begin
        #1;
        check_eq("reset_busy", {31'd0, busy_a}, 32'd0);
        check_eq("reset_h", {22'd0, h_a}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check_eq("idle_busy", {31'd0, busy_a}, 32'd0);
        check_eq("idle_ack", {31'd0, ack_a}, 32'd0);

        // right-moving flight to the right edge; b has no cooldown
        launch(10'd100, 10'd100, 10'd10, 10'd0, 1'b0, 1'b0);
        check_eq("t1_ack", {31'd0, ack_b}, 32'd1);
        check_eq("t1_active", {31'd0, act_b}, 32'd1);
        check_eq("t1_h0", {22'd0, h_b}, 32'd100);
        step();
        check_eq("t1_ack_drop", {31'd0, ack_b}, 32'd0);
        for (int k = 1; k <= 63; k++) begin
            tick();
            check_eq("t1_h_step", {22'd0, h_b}, 32'(100 + 10 * k));
        end
        check_eq("t1_v_still", {22'd0, v_b}, 32'd100);
        tick();
        check_eq("t1_exit_busy_b", {31'd0, busy_b}, 32'd0);
        check_eq("t1_exit_h_b", {22'd0, h_b}, 32'd730);
        check_eq("t1_exit_act_a", {31'd0, act_a}, 32'd0);
        check_eq("t1_exit_noboom_a", {31'd0, exp_a}, 32'd0);
        check_eq("t1_cool_busy_a", {31'd0, busy_a}, 32'd1);
        for (int k = 1; k <= 29; k++) tick();
        check_eq("t1_cool29_busy_a", {31'd0, busy_a}, 32'd1);
        tick();
        check_eq("t1_cool30_busy_a", {31'd0, busy_a}, 32'd0);

        // left edge exit on the first tick
        launch(10'd5, 10'd300, 10'd10, 10'd0, 1'b1, 1'b0);
        check_eq("t2_ack", {31'd0, ack_a}, 32'd1);
        tick();
        check_eq("t2_act_a", {31'd0, act_a}, 32'd0);
        check_eq("t2_busy_a", {31'd0, busy_a}, 32'd1);
        check_eq("t2_h_a", {22'd0, h_a}, 32'd5);
        check_eq("t2_busy_b", {31'd0, busy_b}, 32'd0);
        for (int k = 1; k <= 29; k++) tick();
        check_eq("t2_cool_busy", {31'd0, busy_a}, 32'd1);
        check_eq("t2_cool_h", {22'd0, h_a}, 32'd5);
        tick();
        check_eq("t2_done_busy", {31'd0, busy_a}, 32'd0);

        // hit together with frame_tick, then launch_req held through BOOM/COOL
        launch(10'd200, 10'd200, 10'd5, 10'd5, 1'b0, 1'b0);
        tick();
        check_eq("t3_h_step", {22'd0, h_a}, 32'd205);
        hit = 1'b1; frame_tick = 1'b1;
        step();
        hit = 1'b0; frame_tick = 1'b0;
        check_eq("t3_exploding", {31'd0, exp_a}, 32'd1);
        check_eq("t3_active", {31'd0, act_a}, 32'd0);
        check_eq("t3_h_frozen", {22'd0, h_a}, 32'd205);
        check_eq("t3_v_frozen", {22'd0, v_a}, 32'd205);
        launch_h = 10'd50; launch_v = 10'd60; launch_h_speed = 10'd0; launch_v_speed = 10'd0;
        launch_h_neg = 1'b0; launch_v_neg = 1'b0;
        launch_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            hit = 1'b1;
            tick();
            hit = 1'b0;
            check_eq("t3_boom_exp_a", {31'd0, exp_a}, 32'd1);
            check_eq("t3_boom_ack_a", {31'd0, ack_a}, 32'd0);
            check_eq("t3_boom_ack_b", {31'd0, ack_b}, 32'd0);
        end
        tick();
        check_eq("t3_boom_end_a", {31'd0, exp_a}, 32'd0);
        check_eq("t3_cool_busy_a", {31'd0, busy_a}, 32'd1);
        check_eq("t3_idle_busy_b", {31'd0, busy_b}, 32'd0);
        check_eq("t3_idle_ack_b", {31'd0, ack_b}, 32'd0);
        tick();
        check_eq("t4_ack_b", {31'd0, ack_b}, 32'd1);
        check_eq("t4_cool_ack_a", {31'd0, ack_a}, 32'd0);
        for (int k = 2; k <= 29; k++) begin
            tick();
            check_eq("t4_cool_ack_a", {31'd0, ack_a}, 32'd0);
        end
        check_eq("t4_cool_busy_a", {31'd0, busy_a}, 32'd1);
        tick();
        check_eq("t4_idle_busy_a", {31'd0, busy_a}, 32'd0);
        check_eq("t4_idle_ack_a", {31'd0, ack_a}, 32'd0);
        step();
        launch_req = 1'b0;
        check_eq("t4_late_ack_a", {31'd0, ack_a}, 32'd1);
        check_eq("t4_late_h_a", {22'd0, h_a}, 32'd50);
        check_eq("t4_b_still_fly", {31'd0, act_b}, 32'd1);
        step();
        check_eq("t4_ack_drop_a", {31'd0, ack_a}, 32'd0);

        // asynchronous reset mid-flight
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
        launch(10'd360, 10'd100, 10'd20, 10'd0, 1'b0, 1'b0);
        tick(); tick();
        check_eq("t5_h400", {22'd0, h_a}, 32'd400);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_rst_h", {22'd0, h_a}, 32'd0);
        check_eq("t5_rst_act", {31'd0, act_a}, 32'd0);
        check_eq("t5_rst_busy", {31'd0, busy_a}, 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        check_eq("t5_post_busy", {31'd0, busy_a}, 32'd0);

        // downward flight near the bottom edge
        launch(10'd100, 10'd500, 10'd0, 10'd20, 1'b0, 1'b0);
        tick();
        check_eq("t6_v_step", {22'd0, v_b}, 32'd520);
        check_eq("t6_still_act", {31'd0, act_b}, 32'd1);
        tick();
        check_eq("t6_exit_busy_b", {31'd0, busy_b}, 32'd0);
        check_eq("t6_exit_v_b", {22'd0, v_b}, 32'd520);
        check_eq("t6_exit_noboom_b", {31'd0, exp_b}, 32'd0);
        check_eq("t6_cool_a", {31'd0, busy_a}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
